// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line, per-frame configuration and the decoded word/flags.
interface uart_rx_cfg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 16
);
    logic             i_rx;
    logic [DIV_W-1:0] i_divisor;
    logic [1:0]       i_parity_mode;
    logic             i_two_stop;
    logic [WIDTH-1:0] o_data;
    logic             o_data_valid;
    logic             o_parity_err;
    logic             o_frame_err;
    logic             o_break;
    logic             o_busy;

    modport master (
        output i_rx, i_divisor, i_parity_mode, i_two_stop,
        input  o_data, o_data_valid, o_parity_err, o_frame_err, o_break, o_busy
    );

    modport slave (
        input  i_rx, i_divisor, i_parity_mode, i_two_stop,
        output o_data, o_data_valid, o_parity_err, o_frame_err, o_break, o_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with 3-sample voting, false-start rejection,
// parity/framing checks and break detection.
module uart_rx_cfg #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          i_reset_n,
    uart_rx_cfg_if.slave  bus
);
    localparam int unsigned BIT_W   = $clog2(WIDTH + 1);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q;
    logic [FLUSH_W-1:0]     flush_q;
    logic                   armed_q;

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, half, mid;
    logic [1:0]       pmode_q, pmode_d;
    logic             two_q, two_d;
    logic             s0_q, s0_d, s1_q, s1_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             stop_q, stop_d;
    logic             par_q, par_d;
    logic             stop1_q, stop1_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, perr_q, perr_d, ferr_out_q, ferr_out_d;
    logic             brk_q, brk_d, busy_q, busy_d;
    logic             vote, par_en, first_stop, brk_now, ferr_now;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign half       = div_q >> 1;
    assign mid        = half + DIV_W'(1);
    assign vote       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign par_en     = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign first_stop = stop_q ? stop1_q : vote;

    // Synchronizer; a start is only armed once the flushed line has been seen high.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            flush_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.i_rx};
            rx_prev_q <= rx_s;
            if (flush_q != FLUSH_W'(SYNC_STAGES)) flush_q <= flush_q + FLUSH_W'(1);
            else if (rx_s)                         armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state, bit timer, sampling and output decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pmode_d    = pmode_q;
        two_d      = two_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        par_d      = par_q;
        stop1_d    = stop1_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_out_d = ferr_out_q;
        brk_d      = 1'b0;
        brk_now    = 1'b0;
        ferr_now   = ferr_q;

        if (state_q != S_IDLE) begin
            cnt_d = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
            if (cnt_q == half - DIV_W'(1)) s0_d = rx_s;
            if (cnt_q == half)             s1_d = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && rx_prev_q && !rx_s) begin
                    div_d   = (bus.i_divisor < DIV_MIN) ? DIV_MIN : bus.i_divisor;
                    pmode_d = bus.i_parity_mode;
                    two_d   = bus.i_two_stop;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == mid) state_d = vote ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt_q == mid) begin
                    sh_d  = {vote, sh_q[WIDTH-1:1]};
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(WIDTH - 1)) state_d = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == mid) begin
                    par_d   = vote;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == mid) begin
                    ferr_now = ferr_q | ~vote;
                    if (!stop_q) stop1_d = vote;
                    if (!two_q || stop_q) begin
                        brk_now = (sh_q == '0) && (!par_en || !par_q) && !first_stop;
                        if (brk_now) begin
                            brk_d   = 1'b1;
                            state_d = S_BREAK_WAIT;
                        end else begin
                            valid_d    = 1'b1;
                            data_d     = sh_q;
                            perr_d     = par_en & (^sh_q ^ par_q ^ (pmode_q == 2'b10));
                            ferr_out_d = ferr_now;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                        ferr_d = ferr_now;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_MIN;
            pmode_q    <= 2'b00;
            two_q      <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            sh_q       <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            stop1_q    <= 1'b1;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pmode_q    <= pmode_d;
            two_q      <= two_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            stop1_q    <= stop1_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_out_q;
    assign bus.o_break      = brk_q;
    assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames, parity, framing, break, glitch voting, reconfig, reset.
module tb_uart_rx_cfg;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int LAT_434 = (SYNC_STAGES + 1) + (WIDTH + 1) * 434 + 217 + 2;

    logic clk = 1'b0;
    logic i_reset_n;
    always #10 clk = ~clk;

    uart_rx_cfg_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    uart_rx_cfg #(.WIDTH(WIDTH), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int break_cnt = 0;
    int exp_valid = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;
    logic [7:0] rx_q[$];

    // Pulse capture on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus.o_data_valid) begin
            valid_cnt++;
            last_data = bus.o_data;
            last_perr = bus.o_parity_err;
            last_ferr = bus.o_frame_err;
            rx_q.push_back(bus.o_data);
        end
        if (bus.o_break) break_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int div, input logic [1:0] pm, input logic two);
        bus.i_divisor     = DIV_W'(div);
        bus.i_parity_mode = pm;
        bus.i_two_stop    = two;
    endtask

    // par < 0: no parity bit; gbit >= 0 flips one clock at vote sample gk of that bit.
    task automatic send_frame(input logic [7:0] data, input int par, input logic stop1,
                              input int nstop, input int div, input int gbit, input int gk);
        logic bits [12];
        int nb;
        int m;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = data[i]; nb++; end
        if (par >= 0) begin bits[nb] = par[0]; nb++; end
        bits[nb] = stop1; nb++;
        if (nstop == 2) begin bits[nb] = 1'b1; nb++; end
        for (int i = 0; i < nb; i++) begin
            if (i == gbit) begin
                m = (div / 2) + 1 + gk;
                bus.i_rx = bits[i];  clocks(m - 1);
                bus.i_rx = ~bits[i]; clocks(1);
                bus.i_rx = bits[i];  clocks(div - m);
            end else begin
                bus.i_rx = bits[i];
                clocks(div);
            end
        end
        bus.i_rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        exp_valid++;
        chk({tag, "_count"}, valid_cnt, exp_valid);
        chk({tag, "_data"}, last_data, d);
        chk({tag, "_perr"}, last_perr, pe);
        chk({tag, "_ferr"}, last_ferr, fe);
    endtask

    int g_div  [8] = '{16, 16, 24, 24, 32, 32, 48, 48};
    logic [7:0] g_dat [8] = '{8'h5A, 8'hA5, 8'hF0, 8'h0F, 8'h33, 8'hCC, 8'h69, 8'h96};
    int g_bit  [8] = '{0, 3, 5, 9, 1, 8, 4, 9};
    int g_k    [8] = '{0, 1, 2, 1, 2, 0, 1, 2};

    initial begin
        int  lat;
        bit  found;

        bus.i_rx  = 1'b1;
        cfg(434, 2'b00, 1'b0);
        i_reset_n = 1'b0;
        clocks(3);
        chk("rst_valid", bus.o_data_valid, 0);
        chk("rst_data",  bus.o_data, 0);
        chk("rst_busy",  bus.o_busy, 0);
        chk("rst_break", bus.o_break, 0);
        chk("rst_perr",  bus.o_parity_err, 0);
        chk("rst_ferr",  bus.o_frame_err, 0);
        i_reset_n = 1'b1;
        clocks(10);

        // Basic frame and latency at divisor 434
        lat = 0;
        found = 0;
        fork
            send_frame(8'hA5, -1, 1'b1, 1, 434, -1, 0);
            begin
                while (!found && lat < 6000) begin
                    @(posedge clk); #1;
                    lat++;
                    if (bus.o_data_valid) found = 1;
                end
            end
        join
        chk("t1_found", found, 1);
        chk("t1_latency", lat, LAT_434);
        clocks(434);
        expect_word("t1", 8'hA5, 1'b0, 1'b0);

        // Parity modes
        cfg(32, 2'b01, 1'b0);
        send_frame(8'h3C, 0, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t2_even_ok", 8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t2_even_bad", 8'h3C, 1'b1, 1'b0);
        cfg(32, 2'b10, 1'b0);
        send_frame(8'h3C, 1, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t2_odd_ok", 8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 0, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t2_odd_bad", 8'h3C, 1'b1, 1'b0);

        // Framing error then recovery
        cfg(32, 2'b00, 1'b0);
        send_frame(8'h55, -1, 1'b0, 1, 32, -1, 0); clocks(64);
        expect_word("t3_ferr", 8'h55, 1'b0, 1'b1);
        send_frame(8'h12, -1, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t3_ok", 8'h12, 1'b0, 1'b0);

        // Break: line low for 12 bit times
        bus.i_rx = 1'b0;
        clocks(12 * 32);
        bus.i_rx = 1'b1;
        clocks(64);
        chk("t4_break_cnt", break_cnt, 1);
        chk("t4_no_valid", valid_cnt, exp_valid);
        chk("t4_idle", bus.o_busy, 0);
        send_frame(8'h81, -1, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t4_after", 8'h81, 1'b0, 1'b0);

        // False start: 100-clock glitch at divisor 434
        cfg(434, 2'b00, 1'b0);
        bus.i_rx = 1'b0;
        clocks(50);
        chk("t5_busy_glitch", bus.o_busy, 1);
        clocks(50);
        bus.i_rx = 1'b1;
        clocks(334);
        chk("t5_busy_back", bus.o_busy, 0);
        chk("t5_no_valid", valid_cnt, exp_valid);
        chk("t5_no_break", break_cnt, 1);

        // Single-sample noise must be outvoted
        for (int c = 0; c < 8; c++) begin
            cfg(g_div[c], 2'b00, 1'b0);
            send_frame(g_dat[c], -1, 1'b1, 1, g_div[c], g_bit[c], g_k[c]);
            clocks(2 * g_div[c]);
            expect_word($sformatf("t5_vote%0d", c), g_dat[c], 1'b0, 1'b0);
        end

        // Divisor below 4 clamps to 4
        cfg(1, 2'b00, 1'b0);
        send_frame(8'h96, -1, 1'b1, 1, 4, -1, 0); clocks(16);
        expect_word("t5_clamp", 8'h96, 1'b0, 1'b0);

        // Divisor change mid-frame takes effect on the next frame
        cfg(434, 2'b00, 1'b0);
        fork
            send_frame(8'hC3, -1, 1'b1, 1, 434, -1, 0);
            begin clocks(2000); bus.i_divisor = DIV_W'(217); end
        join
        clocks(434);
        expect_word("t6_old_div", 8'hC3, 1'b0, 1'b0);
        send_frame(8'h3A, -1, 1'b1, 1, 217, -1, 0); clocks(434);
        expect_word("t6_new_div", 8'h3A, 1'b0, 1'b0);

        // Back-to-back frames with two stop bits
        cfg(217, 2'b00, 1'b1);
        send_frame(8'hDE, -1, 1'b1, 2, 217, -1, 0);
        send_frame(8'hAD, -1, 1'b1, 2, 217, -1, 0);
        clocks(434);
        exp_valid += 2;
        chk("t6_b2b_count", valid_cnt, exp_valid);
        chk("t6_b2b_first", rx_q[rx_q.size() - 2], 8'hDE);
        chk("t6_b2b_second", last_data, 8'hAD);
        chk("t6_b2b_ferr", last_ferr, 0);

        // Reset mid-frame; line is still low at release
        cfg(32, 2'b00, 1'b0);
        fork
            send_frame(8'h0F, -1, 1'b1, 1, 32, -1, 0);
            begin
                clocks(170);
                i_reset_n = 1'b0;
                #1;
                chk("t6_rst_busy", bus.o_busy, 0);
                chk("t6_rst_data", bus.o_data, 0);
                clocks(3);
                i_reset_n = 1'b1;
            end
        join
        clocks(64);
        chk("t6_rst_no_valid", valid_cnt, exp_valid);
        chk("t6_rst_no_break", break_cnt, 1);
        chk("t6_rst_idle", bus.o_busy, 0);
        send_frame(8'h5A, -1, 1'b1, 1, 32, -1, 0); clocks(64);
        expect_word("t6_after_rst", 8'h5A, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
